// File: rtl/b_acs_213_pkg.sv
// Shared constants and trellis helpers for the (2,1,3) add-compare-select unit.
package b_acs_213_pkg;

    localparam int unsigned NStates       = 8;
    localparam int unsigned NBr           = 16;
    localparam int unsigned HdW           = 2;
    localparam int unsigned PmWDefault    = 6;
    localparam int unsigned InitPmDefault = 8;

    // Predecessor of branch b into next state j.
    function automatic logic [2:0] pred(input logic [2:0] j, input logic b);
        return {j[1:0], b};
    endfunction

endpackage

// File: rtl/b_acs_213_if.sv
// Step-input / decision-output bundle between the BMU, the ACS and the survivor memory.
interface b_acs_213_if #(
    parameter int unsigned PM_W = 6
);
    logic            start;
    logic            in_valid;
    logic [31:0]     hd_bus;
    logic [7:0]      dec;
    logic            dec_valid;
    logic [2:0]      best_state;
    logic [PM_W-1:0] best_metric;
    logic            best_valid;
    logic            norm_event;

    modport master (
        output start, in_valid, hd_bus,
        input  dec, dec_valid, best_state, best_metric, best_valid, norm_event
    );

    modport slave (
        input  start, in_valid, hd_bus,
        output dec, dec_valid, best_state, best_metric, best_valid, norm_event
    );
endinterface

// File: rtl/b_acs_butterfly_213.sv
// One ACS cell: two candidate adds, modulo compare, select. Ties go to branch 0.
module b_acs_butterfly_213 #(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      hd0_i,
    input  logic [1:0]      hd1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);
    logic [PM_W:0]   cand0, cand1;
    logic [PM_W-1:0] diff;
    logic            unused_carry;

    always_comb begin
        cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, hd0_i};
        cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, hd1_i};
        // Metrics wrap; the sign of the PM_W-bit difference orders them.
        diff  = cand1[PM_W-1:0] - cand0[PM_W-1:0];
        dec_o = diff[PM_W-1];
        pm_o  = dec_o ? cand1[PM_W-1:0] : cand0[PM_W-1:0];
    end

    assign unused_carry = cand0[PM_W] ^ cand1[PM_W];

endmodule

// File: rtl/b_acs_213.sv
// ACS stage of the (2,1,3) Viterbi decoder: path metric registers, normalisation and
// a registered min-tree reporting the best state one cycle after each update.
module b_acs_213
    import b_acs_213_pkg::*;
#(
    parameter int unsigned PM_W    = PmWDefault,
    parameter int unsigned INIT_PM = InitPmDefault
) (
    input logic              clock,
    input logic              reset,
    b_acs_213_if.slave       bus
);
    localparam logic [PM_W-1:0] InitPm = PM_W'(INIT_PM);

    logic [PM_W-1:0] pm_q [NStates];
    logic [PM_W-1:0] pm_d [NStates];
    logic [PM_W-1:0] old_pm [NStates];
    logic [PM_W-1:0] acs_pm [NStates];
    logic [7:0]      acs_dec;
    logic            all_msb;

    logic [7:0]      dec_q, dec_d;
    logic            dec_valid_q, dec_valid_d;
    logic            norm_event_q, norm_event_d;
    logic [2:0]      best_state_q, best_state_d;
    logic [PM_W-1:0] best_metric_q, best_metric_d;
    logic            best_valid_q, best_valid_d;

    logic [2:0]      l1_idx [4];
    logic [PM_W-1:0] l1_val [4];
    logic [2:0]      l2_idx [2];
    logic [PM_W-1:0] l2_val [2];

    // A frame start feeds the initial metrics straight into the ACS.
    always_comb begin
        for (int i = 0; i < NStates; i++) begin
            if (bus.start) begin
                old_pm[i] = (i == 0) ? '0 : InitPm;
            end else begin
                old_pm[i] = pm_q[i];
            end
        end
    end

    for (genvar j = 0; j < NStates; j++) begin : g_bfly
        b_acs_butterfly_213 #(
            .PM_W (PM_W)
        ) u_bfly (
            .pm0_i (old_pm[pred(3'(j), 1'b0)]),
            .pm1_i (old_pm[pred(3'(j), 1'b1)]),
            .hd0_i (bus.hd_bus[4*j+1 -: 2]),
            .hd1_i (bus.hd_bus[4*j+3 -: 2]),
            .pm_o  (acs_pm[j]),
            .dec_o (acs_dec[j])
        );
    end

    always_comb begin
        all_msb = 1'b1;
        for (int i = 0; i < NStates; i++) begin
            all_msb = all_msb & acs_pm[i][PM_W-1];
        end

        for (int i = 0; i < NStates; i++) begin
            pm_d[i] = pm_q[i];
            if (bus.in_valid) begin
                pm_d[i] = acs_pm[i];
                if (all_msb) begin
                    pm_d[i][PM_W-1] = 1'b0;
                end
            end else if (bus.start) begin
                pm_d[i] = (i == 0) ? '0 : InitPm;
            end
        end

        dec_d        = bus.in_valid ? acs_dec : dec_q;
        dec_valid_d  = bus.in_valid;
        norm_event_d = bus.in_valid & all_msb;
    end

    // Min-tree over the stored metrics; the left (lower index) operand wins ties.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (pm_q[2*i+1] < pm_q[2*i]) begin
                l1_idx[i] = 3'(2*i+1);
                l1_val[i] = pm_q[2*i+1];
            end else begin
                l1_idx[i] = 3'(2*i);
                l1_val[i] = pm_q[2*i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (l1_val[2*i+1] < l1_val[2*i]) begin
                l2_idx[i] = l1_idx[2*i+1];
                l2_val[i] = l1_val[2*i+1];
            end else begin
                l2_idx[i] = l1_idx[2*i];
                l2_val[i] = l1_val[2*i];
            end
        end

        best_state_d  = best_state_q;
        best_metric_d = best_metric_q;
        if (dec_valid_q) begin
            if (l2_val[1] < l2_val[0]) begin
                best_state_d  = l2_idx[1];
                best_metric_d = l2_val[1];
            end else begin
                best_state_d  = l2_idx[0];
                best_metric_d = l2_val[0];
            end
        end
        best_valid_d = dec_valid_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NStates; i++) begin
                pm_q[i] <= (i == 0) ? '0 : InitPm;
            end
            dec_q         <= '0;
            dec_valid_q   <= 1'b0;
            norm_event_q  <= 1'b0;
            best_state_q  <= '0;
            best_metric_q <= '0;
            best_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NStates; i++) begin
                pm_q[i] <= pm_d[i];
            end
            dec_q         <= dec_d;
            dec_valid_q   <= dec_valid_d;
            norm_event_q  <= norm_event_d;
            best_state_q  <= best_state_d;
            best_metric_q <= best_metric_d;
            best_valid_q  <= best_valid_d;
        end
    end

    assign bus.dec         = dec_q;
    assign bus.dec_valid   = dec_valid_q;
    assign bus.norm_event  = norm_event_q;
    assign bus.best_state  = best_state_q;
    assign bus.best_metric = best_metric_q;
    assign bus.best_valid  = best_valid_q;

endmodule

// File: tb/tb_b_acs_213.sv
// Directed bench for b_acs_213: reset, ties, normalisation, frame start, clean stream, reset.
module tb_b_acs_213;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_err;

    b_acs_213_if #(.PM_W(6)) bus ();

    b_acs_213 #(
        .PM_W    (6),
        .INIT_PM (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [31:0] hd);
        bus.start    = s;
        bus.in_valid = v;
        bus.hd_bus   = hd;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".dec"},         32'(bus.dec),         32'h0);
        chk({tag, ".dec_valid"},   32'(bus.dec_valid),   32'h0);
        chk({tag, ".best_state"},  32'(bus.best_state),  32'h0);
        chk({tag, ".best_metric"}, 32'(bus.best_metric), 32'h0);
        chk({tag, ".best_valid"},  32'(bus.best_valid),  32'h0);
        chk({tag, ".norm_event"},  32'(bus.norm_event),  32'h0);
    endtask

    // Bench-side encoder output for a transition from register p with input bit u.
    function automatic logic [1:0] enc(input logic [2:0] p, input logic u);
        return {u ^ p[2] ^ p[1] ^ p[0], u ^ p[1] ^ p[0]};
    endfunction

    int          pm_m [8];
    int          hdm  [8][2];
    logic [2:0]  enc_st;
    logic [31:0] hd_v;
    logic [7:0]  exp_dec;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.hd_bus   = '0;
        #12;
        chk_reset_vals("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // One all-zero step from reset: pm becomes {0,8,8,8,0,8,8,8}.
        step(1'b0, 1'b1, 32'h0);
        chk("t1.dec_valid", 32'(bus.dec_valid), 32'h1);
        chk("t1.dec", 32'(bus.dec), 32'h00);
        chk("t1.best_valid_early", 32'(bus.best_valid), 32'h0);
        chk("t1.norm", 32'(bus.norm_event), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t1.dec_valid_drop", 32'(bus.dec_valid), 32'h0);
        chk("t1.best_valid", 32'(bus.best_valid), 32'h1);
        chk("t1.best_state", 32'(bus.best_state), 32'h0);
        chk("t1.best_metric", 32'(bus.best_metric), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t1.best_valid_drop", 32'(bus.best_valid), 32'h0);

        // HD(1)=2: state 0 candidates 2 vs 8; then HD(3)=HD(4)=1 ties state 1 at 9.
        pulse_reset();
        step(1'b0, 1'b1, 32'h0000_0002);
        chk("t2.dec", 32'(bus.dec), 32'h00);
        step(1'b0, 1'b1, 32'h0000_0050);
        chk("t2.tie_dec", 32'(bus.dec), 32'h00);
        chk("t2.best_state", 32'(bus.best_state), 32'h4);
        chk("t2.best_metric", 32'(bus.best_metric), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t2.best_state2", 32'(bus.best_state), 32'h2);
        chk("t2.best_metric2", 32'(bus.best_metric), 32'h0);

        // All HD=2: metrics settle equal and reach 32 on step 16, which normalises to 0.
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 32'hAAAA_AAAA);
        end
        chk("t3.norm_before", 32'(bus.norm_event), 32'h0);
        step(1'b0, 1'b1, 32'hAAAA_AAAA);
        chk("t3.norm", 32'(bus.norm_event), 32'h1);
        chk("t3.norm_dec", 32'(bus.dec), 32'h00);
        chk("t3.best_metric_30", 32'(bus.best_metric), 32'd30);
        step(1'b0, 1'b1, 32'hAA2A_AAAA);
        chk("t3.norm_drop", 32'(bus.norm_event), 32'h0);
        chk("t3.dec5", 32'(bus.dec), 32'h20);
        chk("t3.best_metric_norm", 32'(bus.best_metric), 32'h0);
        chk("t3.best_state_norm", 32'(bus.best_state), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t3.best_state5", 32'(bus.best_state), 32'h5);
        chk("t3.best_metric5", 32'(bus.best_metric), 32'h0);

        // Stored pm is {2,2,2,2,2,0,2,2}; stale metrics would set dec[2].
        step(1'b1, 1'b1, 32'h0);
        chk("t4.start_dec", 32'(bus.dec), 32'h00);
        chk("t4.start_dec_valid", 32'(bus.dec_valid), 32'h1);
        step(1'b0, 1'b1, 32'h0);
        chk("t4.dec_b", 32'(bus.dec), 32'h00);
        chk("t4.best_metric", 32'(bus.best_metric), 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t4.start_alone_dv", 32'(bus.dec_valid), 32'h0);
        // After reload, HD(3)=2 makes branch 1 win into state 1 (10 vs 8).
        step(1'b0, 1'b1, 32'h0000_0020);
        chk("t4.reload_dec", 32'(bus.dec), 32'h02);
        chk("t4.reload_best_valid", 32'(bus.best_valid), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t4.reload_best_state", 32'(bus.best_state), 32'h0);

        // Error-free encoded stream, 64 back-to-back steps against an integer model.
        pm_m[0] = 0;
        for (int k = 1; k < 8; k++) pm_m[k] = 8;
        enc_st = 3'b000;
        for (int i = 0; i < 64; i++) begin
            logic       u;
            logic [1:0] c;
            int         nxt [8];
            u = 1'($urandom_range(0, 1));
            c = enc(enc_st, u);
            hd_v = '0;
            for (int j = 0; j < 8; j++) begin
                for (int b = 0; b < 2; b++) begin
                    logic [2:0] jj;
                    logic [1:0] x;
                    jj = 3'(j);
                    x  = c ^ enc({jj[1:0], 1'(b)}, jj[2]);
                    hdm[j][b] = int'(x[0]) + int'(x[1]);
                    hd_v[4*j+2*b +: 2] = 2'(hdm[j][b]);
                end
            end
            for (int j = 0; j < 8; j++) begin
                int c0, c1;
                c0 = pm_m[(2*j) % 8] + hdm[j][0];
                c1 = pm_m[(2*j) % 8 + 1] + hdm[j][1];
                exp_dec[j] = (c1 < c0);
                nxt[j] = (c1 < c0) ? c1 : c0;
            end
            for (int j = 0; j < 8; j++) pm_m[j] = nxt[j];
            enc_st = {u, enc_st[2:1]};
            step((i == 0), 1'b1, hd_v);
            chk("t5.dec_valid", 32'(bus.dec_valid), 32'h1);
            chk($sformatf("t5.dec[%0d]", i), 32'(bus.dec), 32'(exp_dec));
            if (i > 0) begin
                chk("t5.best_valid", 32'(bus.best_valid), 32'h1);
                chk("t5.best_metric", 32'(bus.best_metric), 32'h0);
            end
        end

        // Reset mid-stream drops the pending best_* strobe.
        reset = 1'b1;
        #1;
        chk_reset_vals("t6.rst");
        @(posedge clock);
        #1;
        chk("t6.dv_in_rst", 32'(bus.dec_valid), 32'h0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        chk("t6.dv_after", 32'(bus.dec_valid), 32'h0);
        chk("t6.bv_after", 32'(bus.best_valid), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t6.bv_after2", 32'(bus.best_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
